// File: rtl/operand_capture.sv
// Operand capture front end for the sign-magnitude multiplier.
// Synchronizes the switches and the push-button, then debounces the button.
// Two operands are captured on successive presses. After that the block
// issues a start pulse, tracks the busy window and shows the result until
// the next press.
module operand_capture #(
    parameter int DW              = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW:0]   i_sw,
    input  logic          i_btn,
    input  logic          i_stop,
    output logic [DW-1:0] o_op_a,
    output logic [DW-1:0] o_op_b,
    output logic          o_sign,
    output logic          o_start,
    output logic          o_busy,
    output logic [2:0]    o_state
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_START,
        S_RUN,
        S_SHOW
    } state_t;

    state_t        state_reg, state_next;
    logic [DW:0]   sw_meta_reg, sw_sync_reg;
    logic          btn_meta_reg, btn_sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          btn_db_reg;
    logic          btn_ev;
    logic [DW-1:0] op_a_reg, op_b_reg;
    logic          sign_a_reg, sign_reg;
    logic          busy_reg;
    logic          run_first_reg;
    logic [2:0]    led_reg, led_next;

    // Two-flop synchronizers for the switches and the raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
        end else begin
            sw_meta_reg  <= i_sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= i_btn;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    // Debounce: accept a level change only after it stays stable long enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            btn_db_reg <= 1'b0;
        end else if (btn_sync_reg == btn_db_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg    <= '0;
            btn_db_reg <= ~btn_db_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The press event fires on the edge where the debounced level goes 0->1
    assign btn_ev = btn_sync_reg && !btn_db_reg && (cnt_reg == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_WAIT_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status LED decode of the upcoming state
    always_comb begin
        state_next = state_reg;
        led_next   = 3'b000;
        case (state_reg)
            S_WAIT_A: if (btn_ev) state_next = S_WAIT_B;
            S_WAIT_B: if (btn_ev) state_next = S_START;
            S_START:  state_next = S_RUN;
            // A stale stop left over from the previous operation is ignored
            // during the first RUN cycle.
            S_RUN:    if (i_stop && !run_first_reg) state_next = S_SHOW;
            S_SHOW:   if (btn_ev) state_next = S_WAIT_A;
            default:  state_next = S_WAIT_A;
        endcase
        case (state_next)
            S_WAIT_A: led_next = 3'b001;
            S_WAIT_B: led_next = 3'b010;
            S_SHOW:   led_next = 3'b100;
            default:  led_next = 3'b000;
        endcase
    end

    // Operand/sign capture, busy flag and registered status LEDs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            sign_a_reg    <= 1'b0;
            sign_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            run_first_reg <= 1'b0;
            led_reg       <= 3'b001;
        end else begin
            if (btn_ev && state_reg == S_WAIT_A) begin
                op_a_reg   <= sw_sync_reg[DW-1:0];
                sign_a_reg <= sw_sync_reg[DW];
            end
            if (btn_ev && state_reg == S_WAIT_B) begin
                op_b_reg <= sw_sync_reg[DW-1:0];
                sign_reg <= sign_a_reg ^ sw_sync_reg[DW];
            end
            busy_reg      <= (state_next == S_RUN);
            run_first_reg <= (state_reg == S_START);
            led_reg       <= led_next;
        end
    end

    assign o_op_a  = op_a_reg;
    assign o_op_b  = op_b_reg;
    assign o_sign  = sign_reg;
    assign o_start = (state_reg == S_START);
    assign o_busy  = busy_reg;
    assign o_state = led_reg;

endmodule

// File: doc/operand_capture.md
Name: operand_capture

Overview:
- Front end of the PR1 multiplier datapath and the input-side counterpart of the LED output stage.
- Reads operator switches and one push-button, captures two sign-magnitude operands, and issues a single start pulse to the multiplier.
- Waits for the multiplier's done/stop indication, then holds until the operator presses again for the next operation.

Parameters:
- DW, 8: operand magnitude width; product width is 2*DW (16 = product_t).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_sw  in  DW+1  switches: [DW] sign, [DW-1:0] magnitude (asynchronous to clk)
- i_btn  in  1  load/next push-button, active-high, raw and bouncing
- i_stop  in  1  multiplier done; level, held high until the next o_start
- o_op_a  out  DW  captured multiplicand magnitude
- o_op_b  out  DW  captured multiplier magnitude
- o_sign  out  1  result sign = sign_a XOR sign_b
- o_start  out  1  one-cycle start pulse to the multiplier
- o_busy  out  1  high from o_start until i_stop is seen
- o_state  out  3  one-hot status LEDs: [0] waiting for A, [1] waiting for B, [2] result shown

Behaviour:
- Reset (asynchronous, rst=0):
  - o_op_a, o_op_b, o_sign, o_start and o_busy go to 0.
  - o_state goes to 3'b001.
  - FSM goes to WAIT_A.
  - Synchronizer and debounce counter clear; debounced button level clears to 0.
- Synchronizer: i_sw and i_btn each pass through 2 flops before use.
- Debounce:
  - The counter increments while the synchronized button differs from the debounced level and resets to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press event (btn_ev) is a one-cycle pulse on a debounced 0->1 transition only. Release generates nothing.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states and transitions (all on btn_ev unless noted):
  - WAIT_A: on btn_ev, latch the synchronized sw magnitude into o_op_a and the sign into sign_a; go to WAIT_B.
  - WAIT_B: on btn_ev, latch o_op_b and sign_b; o_sign updates to sign_a^sign_b on the same edge; go to START.
  - START: o_start=1 for exactly this one cycle; o_busy goes 1 on the next edge; go to RUN unconditionally.
  - RUN: o_busy=1; btn_ev is ignored (dropped, not queued). When i_stop=1, go to SHOW and o_busy goes 0.
  - SHOW: operands and o_sign held. On btn_ev, go to WAIT_A; operands hold until overwritten.
- o_state is registered and decoded from state: WAIT_A=001, WAIT_B=010, START/RUN=000, SHOW=100.
- Latency:
  - Raw button edge to btn_ev: 2 synchronizer cycles + DEBOUNCE_CYCLES.
  - btn_ev in WAIT_B to o_start high: 1 cycle.
- Boundary conditions:
  - i_stop high on entry to RUN (stale from the previous operation): ignored in the first RUN cycle. The RUN->SHOW check starts from the second RUN cycle; the multiplier guarantees i_stop drops within one cycle of o_start.
  - Switch change between presses: has no effect; only the value present at btn_ev is captured.
  - Zero operands and max operands (2^DW-1) are legal; there is no saturation.
  - Reset asserted mid-RUN aborts immediately. o_busy drops asynchronously; the multiplier is reset by the same rst.
  - Button held down across states: one event per press, never a repeat.

Test Plan:
- Reset then idle: rst low 3 cycles, high; no button activity -> o_state=001, all other outputs 0, no o_start for 200 cycles.
- Bounce rejection: i_btn toggled every 3 cycles for 30 cycles, then held high 40 cycles -> exactly one btn_ev, FSM WAIT_A->WAIT_B, o_op_a = switch value at the event.
- Full operation:
  - Capture A with sw=9'h1_07 (-7), then B with sw=9'h0_0C (+12) -> o_op_a=7, o_op_b=12, o_sign=1.
  - o_start high for 1 cycle; o_busy high.
  - Assert i_stop 20 cycles later -> o_busy=0, o_state=100.
- Press during RUN: btn press while busy -> ignored; after i_stop the FSM is in SHOW, not WAIT_A.
- Sign and extremes: A=+255, B=-255 -> o_sign=1, operands 8'hFF. A=-0, B=-5 -> o_sign=0.
- Reset mid-RUN: rst pulsed low 1 cycle while o_busy=1 -> all outputs return to reset values asynchronously, o_state=001, next press captures A.
